router_egress_collector: RTL and testbench

//  Receiving end of the router's four egress lanes (data/valid, no backpressure).

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_egress_fifo.sv | 47 ++++
 rtl/router_egress_collector.sv | 115 +++++++++++
 tb/tb_router_egress_collector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types, register offsets and the round-robin pick used by the egress collector.
package router_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] port_id_t;

    localparam logic [3:0] REG_OCC    = 4'h0;
    localparam logic [3:0] REG_DROP01 = 4'h4;
    localparam logic [3:0] REG_DROP23 = 4'h8;
    localparam logic [3:0] REG_CLR    = 4'hC;

    // First requester after ptr (ptr itself is searched last); the descending
    // scan lets the nearest candidate overwrite the farther ones.
    function automatic port_id_t rr_grant(input port_id_t ptr, input logic [NUM_PORTS-1:0] req);
        port_id_t g;
        port_id_t c;
        g = ptr;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            c = ptr + port_id_t'(k);
            if (req[c]) g = c;
        end
        return g;
    endfunction

endpackage

// File: rtl/router_egress_fifo.sv
// Single-lane synchronous FIFO; head entry is visible combinationally on dout.
module router_egress_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              wr, rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end

endmodule

// File: rtl/router_egress_collector.sv
// Buffers four unstallable router egress lanes and merges them round-robin onto
// one valid/ready stream, with saturating per-lane drop counters on a register port.
module router_egress_collector
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  data_in,
    input  logic [NUM_PORTS-1:0]              valid_in,
    output logic [DATA_W-1:0]                 out_data,
    output port_id_t                          out_port,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic [3:0]                        reg_addr,
    input  logic                              reg_en,
    input  logic                              reg_we,
    input  logic [31:0]                       reg_wdata,
    output logic [31:0]                       reg_rdata
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0][DATA_W-1:0] fifo_dout;
    logic [NUM_PORTS-1:0][CW-1:0]     fifo_cnt;
    logic [NUM_PORTS-1:0]             fifo_full, fifo_empty, pop, drop;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    port_id_t          out_port_q, out_port_d, ptr_q, ptr_d, grant;
    logic              out_valid_q, out_valid_d;
    logic              free, any_req, clr;
    logic [15:0]       occ;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
        router_egress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (valid_in[i]),
            .pop   (pop[i]),
            .din   (data_in[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (fifo_cnt[i])
        );
        assign pop[i]         = free && any_req && (grant == port_id_t'(i));
        assign drop[i]        = valid_in[i] && fifo_full[i] && !pop[i];
        assign occ[4*i +: 4]  = 4'(fifo_cnt[i]);
    end

    assign free    = !out_valid_q || out_ready;
    assign any_req = |(~fifo_empty);
    assign grant   = rr_grant(ptr_q, ~fifo_empty);
    assign clr     = reg_en && reg_we && (reg_addr == REG_CLR);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        ptr_d       = ptr_q;
        if (free) begin
            out_valid_d = any_req;
            if (any_req) begin
                out_data_d = fifo_dout[grant];
                out_port_d = grant;
                ptr_d      = grant;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            drop_cnt_d[i] = drop_cnt_q[i];
            // Clear beats a simultaneous drop; counters stick at all-ones.
            if (clr)
                drop_cnt_d[i] = '0;
            else if (drop[i] && (drop_cnt_q[i] != '1))
                drop_cnt_d[i] = drop_cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            ptr_q       <= port_id_t'(NUM_PORTS - 1);
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            ptr_q       <= ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_OCC:    reg_rdata = {16'h0, occ};
            REG_DROP01: reg_rdata = {16'(drop_cnt_q[1]), 16'(drop_cnt_q[0])};
            REG_DROP23: reg_rdata = {16'(drop_cnt_q[3]), 16'(drop_cnt_q[2])};
            default:    reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_router_egress_collector.sv
// Directed bench for router_egress_collector: arbitration order, backpressure,
// overflow counting, clear/saturation and mid-operation reset.
module tb_router_egress_collector;
    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][7:0]  data_in;
    logic [3:0]       valid_in;
    logic [7:0]       out_data;
    logic [1:0]       out_port;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       reg_addr;
    logic             reg_en, reg_we;
    logic [31:0]      reg_wdata, reg_rdata;

    int checks = 0;
    int errors = 0;

    router_egress_collector #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .reg_addr(reg_addr), .reg_en(reg_en),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = '0; out_ready = 1'b1;
        reg_en = 1'b0; reg_we = 1'b0; reg_addr = 4'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL reset_port got %0d want 0", out_port); end
        reg_addr = 4'h0; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_occ got %h want 0", reg_rdata); end
        reg_addr = 4'h4; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_drop01 got %h want 0", reg_rdata); end
    endtask

    task automatic test_single_beat();
        do_reset();
        data_in = '0; data_in[2] = 8'hA5; valid_in = 4'b0100;
        tick();
        valid_in = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", out_valid); end
        tick();
        checks++; if ({out_valid, out_port, out_data} !== {1'b1, 2'd2, 8'hA5})
            begin errors++; $display("FAIL single_beat got v%0b p%0d d%h want v1 p2 dA5", out_valid, out_port, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_once got %0b want 0", out_valid); end
    endtask

    task automatic test_rr_burst();
        logic [7:0] base;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            base = (b == 0) ? 8'h10 : 8'h20;
            for (int i = 0; i < 4; i++) data_in[i] = base + 8'(i);
            valid_in = 4'hF;
            tick();
            valid_in = '0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got %0b want 0", b, out_valid); end
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({out_valid, out_port, out_data} !== {1'b1, 2'(i), base + 8'(i)}) begin
                    errors++;
                    $display("FAIL rr_burst%0d_%0d got v%0b p%0d d%h want v1 p%0d d%h",
                             b, i, out_valid, out_port, out_data, i, base + 8'(i));
                end
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_end got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        data_in = '0;
        for (int k = 0; k < 3; k++) begin
            data_in[0] = 8'h30 + 8'(k); valid_in = 4'b0001;
            tick();
        end
        valid_in = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({out_valid, out_port, out_data} !== {1'b1, 2'd0, 8'h30}) begin
                errors++;
                $display("FAIL bp_hold%0d got v%0b p%0d d%h want v1 p0 d30", k, out_valid, out_port, out_data);
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid, out_data} !== {1'b1, 8'h30 + 8'(k)}) begin
                errors++;
                $display("FAIL bp_release%0d got v%0b d%h want v1 d%h", k, out_valid, out_data, 8'h30 + 8'(k));
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        data_in = '0;
        for (int k = 0; k < 7; k++) begin
            data_in[1] = 8'h40 + 8'(k); valid_in = 4'b0010;
            tick();
        end
        valid_in = '0;
        reg_addr = 4'h0; #1;
        checks++; if (reg_rdata !== 32'h0000_0040) begin errors++; $display("FAIL ovf_occ got %h want 00000040", reg_rdata); end
        reg_addr = 4'h4; #1;
        checks++; if (reg_rdata !== 32'h0002_0000) begin errors++; $display("FAIL ovf_drop got %h want 00020000", reg_rdata); end
        checks++; if ({out_valid, out_port, out_data} !== {1'b1, 2'd1, 8'h40})
            begin errors++; $display("FAIL ovf_head got v%0b p%0d d%h want v1 p1 d40", out_valid, out_port, out_data); end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++;
            if ({out_valid, out_data} !== {1'b1, 8'h40 + 8'(k)}) begin
                errors++;
                $display("FAIL ovf_drain%0d got v%0b d%h want v1 d%h", k, out_valid, out_data, 8'h40 + 8'(k));
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_end got %0b want 0", out_valid); end
    endtask

    task automatic test_clear_saturate();
        do_reset();
        out_ready = 1'b0;
        data_in = '0; data_in[3] = 8'h77; valid_in = 4'b1000;
        repeat (5) tick();
        reg_addr = 4'h8; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL clr_fill got %h want 0", reg_rdata); end
        tick();
        checks++; if (reg_rdata !== 32'h0001_0000) begin errors++; $display("FAIL clr_first got %h want 00010000", reg_rdata); end
        reg_en = 1'b1; reg_we = 1'b1; reg_addr = 4'hC; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL clr_read got %h want 0", reg_rdata); end
        tick();
        reg_en = 1'b0; reg_we = 1'b0; reg_addr = 4'h8; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL clr_wins got %h want 0", reg_rdata); end
        tick();
        checks++; if (reg_rdata !== 32'h0001_0000) begin errors++; $display("FAIL clr_resume got %h want 00010000", reg_rdata); end
        repeat (65534) tick();
        checks++; if (reg_rdata !== 32'hFFFF_0000) begin errors++; $display("FAIL sat_reach got %h want FFFF0000", reg_rdata); end
        repeat (3) tick();
        checks++; if (reg_rdata !== 32'hFFFF_0000) begin errors++; $display("FAIL sat_hold got %h want FFFF0000", reg_rdata); end
        reg_addr = 4'h4; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL sat_other got %h want 0", reg_rdata); end
        valid_in = '0;
    endtask

    task automatic test_mid_reset();
        // Continues from the saturated state so the reset must clear counters too.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) data_in[i] = 8'h80 + 8'(4*k + i);
            valid_in = 4'hF;
            tick();
        end
        valid_in = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mr_pre got %0b want 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({out_valid, out_port, out_data} !== {1'b0, 2'd0, 8'h00})
            begin errors++; $display("FAIL mr_out got v%0b p%0d d%h want v0 p0 d00", out_valid, out_port, out_data); end
        reg_addr = 4'h0; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL mr_occ got %h want 0", reg_rdata); end
        reg_addr = 4'h8; #1;
        checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL mr_drop got %h want 0", reg_rdata); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_ghost%0d got %0b want 0", k, out_valid); end
        end
    endtask

    initial begin
        rst = 1'b1; data_in = '0; valid_in = '0; out_ready = 1'b1;
        reg_addr = 4'h0; reg_en = 1'b0; reg_we = 1'b0; reg_wdata = 32'hDEAD_BEEF;
        test_reset();
        test_single_beat();
        test_rr_burst();
        test_backpressure();
        test_overflow();
        test_clear_saturate();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
